// File: rtl/tile_pkg.sv
// Shared constants and state type for the 8x8 systolic tile front end.
package tile_pkg;

  localparam int TILE_SIZE = 8;
  localparam int DATA_W    = 16;
  localparam int SEQ_LEN   = 3*TILE_SIZE-1;
  localparam int VEC_W     = TILE_SIZE*DATA_W;
  localparam int BEAT_W    = $clog2(TILE_SIZE+1);
  localparam int DRAIN_W   = $clog2(2*TILE_SIZE);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} feeder_state_t;

endpackage

// File: rtl/tile_skew_feeder_skew_line.sv
// Enable-gated shift register of DEPTH stages; one instance per edge lane.
module skew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tile_skew_feeder.sv
// Buffers K-step operand beats and emits diagonally skewed row/column edge
// streams for the systolic tile, then drains zeros to finish accumulation.
module tile_skew_feeder
  import tile_pkg::*;
(
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [VEC_W-1:0] IN_A,
  input  logic [VEC_W-1:0] IN_B,
  output logic [VEC_W-1:0] ROW_X,
  output logic [VEC_W-1:0] COL_X,
  output logic             TILE_EN,
  output logic             BUSY,
  output logic             DONE
);

  feeder_state_t        state_q, state_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                 tile_en_q, busy_q, done_q;
  logic                 accept, advance, inDrain;

  assign IN_READY = (state_q == IDLE) || (state_q == LOAD);
  assign accept   = IN_VALID & IN_READY;
  assign inDrain  = (state_q == DRAIN);
  // Every drain cycle shifts a zero in, so the tile keeps accumulating.
  assign advance  = accept | inDrain;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (TILE_SIZE == 1) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end else begin
            state_d    = LOAD;
            beat_cnt_d = BEAT_W'(1);
          end
        end
      end
      LOAD: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (beat_cnt_q == BEAT_W'(TILE_SIZE-1)) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        if (drain_cnt_q == DRAIN_W'(2*TILE_SIZE-2)) state_d = tile_pkg::DONE;
      end
      default: begin
        state_d     = IDLE;
        beat_cnt_d  = '0;
        drain_cnt_d = '0;
      end
    endcase
  end

  // The DONE pulse trails the DONE state by one cycle so BUSY drops exactly as it fires.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      tile_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      tile_en_q   <= advance;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_q == tile_pkg::DONE);
    end
  end

  assign TILE_EN = tile_en_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

  for (genvar i = 0; i < TILE_SIZE; i++) begin : g_lane
    logic [DATA_W-1:0] aIn, bIn;

    assign aIn = inDrain ? '0 : IN_A[i*DATA_W +: DATA_W];
    assign bIn = inDrain ? '0 : IN_B[i*DATA_W +: DATA_W];

    skew_line #(.DEPTH(i+1), .DATA_W(DATA_W)) u_row (
      .clk_i (CLK),
      .rst_ni(RSTN),
      .en_i  (advance),
      .d_i   (aIn),
      .q_o   (ROW_X[i*DATA_W +: DATA_W])
    );

    skew_line #(.DEPTH(i+1), .DATA_W(DATA_W)) u_col (
      .clk_i (CLK),
      .rst_ni(RSTN),
      .en_i  (advance),
      .d_i   (bIn),
      .q_o   (COL_X[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_tile_skew_feeder.sv
// Bench for tile_skew_feeder: advance-count reference model, a small systolic
// tile fed by the DUT edges, and directed scenarios with literal expectations.
module tb_tile_skew_feeder;

  localparam int N   = 8;
  localparam int W   = 16;
  localparam int SEQ = 3*N-1;

  logic           clk = 1'b0;
  logic           rstN = 1'b1;
  logic           inValid = 1'b0;
  logic [N*W-1:0] inA = '0;
  logic [N*W-1:0] inB = '0;
  logic           inReady, tileEn, busy, done;
  logic [N*W-1:0] rowX, colX;

  int checks = 0;
  int errors = 0;

  tile_skew_feeder dut (
    .CLK(clk), .RSTN(rstN), .IN_VALID(inValid), .IN_READY(inReady),
    .IN_A(inA), .IN_B(inB), .ROW_X(rowX), .COL_X(colX),
    .TILE_EN(tileEn), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  // Reference model: position in the 23-advance operation plus the beats taken.
  int             adv = 0;
  logic           eEn = 1'b0, eBusy = 1'b0, eDone = 1'b0;
  logic [N*W-1:0] mA [N];
  logic [N*W-1:0] mB [N];

  // Systolic tile driven by the DUT edges; lastY keeps the latest finished result.
  longint         acc  [N][N];
  longint         lastY[N][N];
  logic [W-1:0]   aR   [N][N];
  logic [W-1:0]   bR   [N][N];

  function automatic logic [W-1:0] lane(input logic [N*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  function automatic logic [N*W-1:0] fillVec(input int x);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(x);
    return v;
  endfunction

  function automatic logic [N*W-1:0] randVec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    inValid = v;
    inA     = a;
    inB     = b;
  endtask

  task automatic clearTile();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc[i][j] = 0;
        aR[i][j]  = '0;
        bR[i][j]  = '0;
      end
  endtask

  initial begin
    forever begin
      int nxt;
      logic acc1;
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        adv = 0; eEn = 1'b0; eBusy = 1'b0; eDone = 1'b0;
      end else begin
        acc1  = (adv < N) && inValid;
        eDone = (adv == SEQ);
        eEn   = acc1 || (adv >= N && adv < SEQ);
        if (acc1) begin
          mA[adv] = inA;
          mB[adv] = inB;
        end
        nxt   = (adv == SEQ) ? 0 : (eEn ? adv + 1 : adv);
        adv   = nxt;
        eBusy = (adv != 0);
      end
    end
  end

  // Per-cycle compare of every output against the model, plus the tile product.
  initial begin
    forever begin
      logic [N*W-1:0] rowE, colE;
      int idx;
      longint yExp;
      logic [W-1:0] a, b;
      @(negedge clk);
      if (!rstN) begin
        clearTile();
      end else begin
        rowE = '0;
        colE = '0;
        for (int i = 0; i < N; i++) begin
          idx = adv - 1 - i;
          if (idx >= 0 && idx < N) begin
            rowE[i*W +: W] = lane(mA[idx], i);
            colE[i*W +: W] = lane(mB[idx], i);
          end
        end
        checkOutput("rowX", rowX, rowE);
        checkOutput("colX", colX, colE);
        checkOutput("tileEn", {127'b0, tileEn}, {127'b0, eEn});
        checkOutput("busy", {127'b0, busy}, {127'b0, eBusy});
        checkOutput("done", {127'b0, done}, {127'b0, eDone});
        checkOutput("inReady", {127'b0, inReady}, {127'b0, (adv < N)});
        if (tileEn) begin
          for (int i = N-1; i >= 0; i--)
            for (int j = N-1; j >= 0; j--) begin
              a = (j == 0) ? lane(rowX, i) : aR[i][j-1];
              b = (i == 0) ? lane(colX, j) : bR[i-1][j];
              acc[i][j] += longint'(a) * longint'(b);
              aR[i][j] = a;
              bR[i][j] = b;
            end
        end
        if (done) begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              yExp = 0;
              for (int k = 0; k < N; k++)
                yExp += longint'(lane(mA[k], i)) * longint'(lane(mB[k], j));
              checkOutput($sformatf("tileY[%0d][%0d]", i, j), 128'(acc[i][j]), 128'(yExp));
              lastY[i][j] = acc[i][j];
            end
          clearTile();
        end
      end
    end
  end

  // One operation with beats k+1 on all lanes, optional bubble after beat 4.
  task automatic driveOp(input int bubLen, input bit holdHigh, input bit pin,
                         output int doneCyc, output int enCnt, output int doneCnt,
                         output int frozenErr);
    int k, bub;
    logic [N*W-1:0] prevRow;
    doneCyc = -1; enCnt = 0; doneCnt = 0; frozenErr = 0;
    k = 1; bub = 0; prevRow = '0;
    @(negedge clk);
    applyStimulus(1'b1, fillVec(1), fillVec(1));
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (tileEn) enCnt++;
      else if (c >= 2 && doneCyc < 0 && rowX !== prevRow) frozenErr++;
      if (done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = c;
      end
      if (pin) begin
        if (c == 1)  checkOutput("pinRow0c1", 128'(lane(rowX, 0)), 128'd1);
        if (c == 1)  checkOutput("pinCol0c1", 128'(lane(colX, 0)), 128'd1);
        if (c == 8)  checkOutput("pinRow0c8", 128'(lane(rowX, 0)), 128'd8);
        if (c == 8)  checkOutput("pinRow7c8", 128'(lane(rowX, 7)), 128'd1);
        if (c == 15) checkOutput("pinRow7c15", 128'(lane(rowX, 7)), 128'd8);
        if (c == 16) checkOutput("pinRowZero", rowX, '0);
        if (c == 23) checkOutput("pinBusyC23", {127'b0, busy}, 128'd1);
        if (c == 24) checkOutput("pinBusyC24", {127'b0, busy}, 128'd0);
      end
      prevRow = rowX;
      if (doneCyc >= 0) begin
        applyStimulus(1'b0, '0, '0);
        if (c >= doneCyc + 2) break;
      end else if (k < N) begin
        if (k == 4 && bub < bubLen) begin
          applyStimulus(1'b0, '0, '0);
          bub++;
        end else begin
          applyStimulus(1'b1, fillVec(k+1), fillVec(k+1));
          k++;
        end
      end else if (holdHigh) begin
        applyStimulus(1'b1, '1, '1);
      end else begin
        applyStimulus(1'b0, '0, '0);
      end
    end
  endtask

  task automatic checkOp(input string tag, input int bubLen, input bit holdHigh, input bit pin);
    int doneCyc, enCnt, doneCnt, frozenErr;
    driveOp(bubLen, holdHigh, pin, doneCyc, enCnt, doneCnt, frozenErr);
    checkOutput({tag, "DoneCycle"}, 128'(doneCyc), 128'(24 + bubLen));
    checkOutput({tag, "EnCount"}, 128'(enCnt), 128'd23);
    checkOutput({tag, "DonePulses"}, 128'(doneCnt), 128'd1);
    checkOutput({tag, "Frozen"}, 128'(frozenErr), 128'd0);
    checkOutput({tag, "Y00"}, 128'(lastY[0][0]), 128'd204);
    checkOutput({tag, "Y73"}, 128'(lastY[7][3]), 128'd204);
  endtask

  task automatic resetInDrain();
    @(negedge clk);
    applyStimulus(1'b1, fillVec(1), fillVec(1));
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c < N) applyStimulus(1'b1, fillVec(c+1), fillVec(c+1));
      else       applyStimulus(1'b0, '0, '0);
    end
    #2 rstN = 1'b0;
    #1;
    checkOutput("abortRow", rowX, '0);
    checkOutput("abortCol", colX, '0);
    checkOutput("abortEn", {127'b0, tileEn}, 128'd0);
    checkOutput("abortBusy", {127'b0, busy}, 128'd0);
    checkOutput("abortDone", {127'b0, done}, 128'd0);
    checkOutput("abortReady", {127'b0, inReady}, 128'd1);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic backToBack();
    int busyLow, doneCnt;
    busyLow = 0; doneCnt = 0;
    @(negedge clk);
    applyStimulus(1'b1, randVec(), randVec());
    for (int c = 1; c <= 47; c++) begin
      @(negedge clk);
      if (!busy) busyLow++;
      if (done) doneCnt++;
      applyStimulus(1'b1, randVec(), randVec());
    end
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    checkOutput("b2bBusyGap", 128'(busyLow), 128'd1);
    checkOutput("b2bDoneFirst", 128'(doneCnt), 128'd1);
    checkOutput("b2bDoneSecond", {127'b0, done}, 128'd1);
  endtask

  task automatic randomPhase();
    bit idle;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      applyStimulus($urandom_range(0, 3) != 0, randVec(), randVec());
    end
    @(negedge clk);
    applyStimulus(1'b0, '0, '0);
    idle = 1'b0;
    for (int t = 0; t < 60 && !idle; t++) begin
      @(negedge clk);
      if (inReady && !busy && !done && adv == 0) idle = 1'b1;
    end
    checkOutput("randomDrainsIdle", {127'b0, idle}, 128'd1);
  endtask

  initial begin
    clearTile();
    for (int k = 0; k < N; k++) begin
      mA[k] = '0;
      mB[k] = '0;
    end
    #1 rstN = 1'b0;
    #1;
    checkOutput("resetRow", rowX, '0);
    checkOutput("resetCol", colX, '0);
    checkOutput("resetEn", {127'b0, tileEn}, 128'd0);
    checkOutput("resetBusy", {127'b0, busy}, 128'd0);
    checkOutput("resetDone", {127'b0, done}, 128'd0);
    checkOutput("resetReady", {127'b0, inReady}, 128'd1);
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] scenario: back-to-back beats");
    checkOp("plain", 0, 1'b0, 1'b1);
    $display("[TB] scenario: three-cycle bubble");
    checkOp("bubble", 3, 1'b0, 1'b0);
    $display("[TB] scenario: reset during drain");
    resetInDrain();
    checkOp("afterAbort", 0, 1'b0, 1'b0);
    $display("[TB] scenario: valid held through drain");
    checkOp("holdValid", 0, 1'b1, 1'b0);
    $display("[TB] scenario: back-to-back operations");
    backToBack();
    $display("[TB] scenario: random traffic");
    randomPhase();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
